// File: rtl/ws2812_pkg.sv
// ws2812_pkg: shared state encoding, pixel width and 12 MHz timing defaults for the WS2812 receiver.
package ws2812_pkg;
   typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} state_e;
   localparam int WS2812_PIXEL_W       = 24;
   localparam int DEF_BIT_THRESH       = 6;
   localparam int DEF_MIN_HIGH         = 2;
   localparam int DEF_MAX_HIGH         = 12;
   localparam int DEF_RESET_CYCLES     = 600;
endpackage

// File: rtl/ws2812_rx_sync.sv
// ws2812_rx_sync: 2-flop synchronizer, optional inversion and registered rise/fall strobes.
module ws2812_rx_sync
   import ws2812_pkg::*;
#(
   parameter bit INVERT = 1'b1
) (
   input  logic clk_in,
   input  logic rst_n,
   input  logic rx_in,
   output logic line_o,
   output logic rise_o,
   output logic fall_o
);
   logic s1_q, s2_q, prev_q, rise_q, fall_q;
   assign line_o = s2_q ^ INVERT;
   assign rise_o = rise_q;
   assign fall_o = fall_q;
   // synchronizer resets to the idle-low level so no false edge follows reset
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         s1_q   <= INVERT;
         s2_q   <= INVERT;
         prev_q <= 1'b0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         s1_q   <= rx_in;
         s2_q   <= s1_q;
         prev_q <= line_o;
         rise_q <= line_o & ~prev_q;
         fall_q <= ~line_o & prev_q;
      end
   end
endmodule

// File: rtl/ws2812_rx.sv
// ws2812_rx: WS2812 stream receiver (pulse-width bit decode, 24-bit pixels, latch-gap detect).
// Define WS2812_RX_PASSTHRU_EN to build the daisy-chain pass-through on dout.
module ws2812_rx
   import ws2812_pkg::*;
#(
   parameter int BIT_THRESH   = DEF_BIT_THRESH,
   parameter int MIN_HIGH     = DEF_MIN_HIGH,
   parameter int MAX_HIGH     = DEF_MAX_HIGH,
   parameter int RESET_CYCLES = DEF_RESET_CYCLES,
   parameter bit INVERT       = 1'b1
) (
   input  logic                      clk_in,
   input  logic                      rst_n,
   input  logic                      rx_in,
   output logic [WS2812_PIXEL_W-1:0] pixel_data,
   output logic [7:0]                pixel_index,
   output logic                      pixel_valid,
   input  logic                      pixel_ready,
   output logic                      frame_done,
   output logic                      err,
   output logic                      overrun,
   output logic                      dout
);
   localparam int CW = $clog2(RESET_CYCLES + 1);
   localparam logic [CW-1:0] C_ONE = CW'(1);
   localparam logic [CW-1:0] C_BT  = CW'(BIT_THRESH);
   localparam logic [CW-1:0] C_MIN = CW'(MIN_HIGH);
   localparam logic [CW-1:0] C_MAX = CW'(MAX_HIGH);
   localparam logic [CW-1:0] C_RC  = CW'(RESET_CYCLES);
   localparam logic [CW-1:0] C_RC1 = CW'(RESET_CYCLES - 1);
   localparam logic [4:0]    C_PW  = 5'(WS2812_PIXEL_W);

   logic line, rise, fall;
   ws2812_rx_sync #(.INVERT(INVERT)) u_sync (
      .clk_in(clk_in),
      .rst_n (rst_n),
      .rx_in (rx_in),
      .line_o(line),
      .rise_o(rise),
      .fall_o(fall)
   );

   state_e                    state_q, state_d;
   logic [CW-1:0]             cnt_q, cnt_d, cnt_inc;
   logic [4:0]                bitcnt_q, bitcnt_d;
   logic [WS2812_PIXEL_W-1:0] sh_q, sh_d, pdata_q, pdata_d;
   logic [7:0]                pos_q, pos_d, pidx_q, pidx_d;
   logic                      valid_q, valid_d, fd_q, fd_d, err_q, err_d, ovr_q, ovr_d;
   logic                      complete;

   assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
   assign complete = (bitcnt_q == C_PW);

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) state_q <= SYNC;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         SYNC:    if (!line && cnt_q == C_RC1) state_d = IDLE;
         IDLE:    if (rise) state_d = HIGH;
         HIGH:    state_d = fall ? ((cnt_q < C_MIN) ? SYNC : LOW) : ((cnt_q > C_MAX) ? SYNC : HIGH);
         LOW:     state_d = rise ? HIGH : ((cnt_q == C_RC) ? IDLE : LOW);
         default: state_d = SYNC;
      endcase
   end

   // one shared counter serves as sync-gap, hcnt and lcnt depending on state
   always_comb begin
      cnt_d    = cnt_inc;
      bitcnt_d = complete ? 5'd0 : bitcnt_q;
      sh_d     = sh_q;
      pdata_d  = complete ? sh_q : pdata_q;
      pidx_d   = complete ? pos_q : pidx_q;
      pos_d    = complete ? ((pos_q == 8'hFF) ? pos_q : pos_q + 8'd1) : pos_q;
      valid_d  = complete | (valid_q & ~pixel_ready);
      ovr_d    = ovr_q | (complete & valid_q & ~pixel_ready);
      fd_d     = 1'b0;
      err_d    = 1'b0;
      case (state_q)
         SYNC: if (line) cnt_d = '0;
         IDLE: cnt_d = C_ONE;
         HIGH: begin
            if (fall && cnt_q >= C_MIN) begin
               sh_d     = {sh_q[WS2812_PIXEL_W-2:0], cnt_q >= C_BT};
               bitcnt_d = bitcnt_q + 5'd1;
               cnt_d    = C_ONE;
            end else if (fall || cnt_q > C_MAX) begin
               err_d    = 1'b1;
               bitcnt_d = 5'd0;
               cnt_d    = '0;
            end
         end
         LOW: begin
            if (rise) begin
               cnt_d = C_ONE;
            end else if (cnt_q == C_RC) begin
               fd_d     = 1'b1;
               err_d    = (bitcnt_q != 5'd0);
               bitcnt_d = 5'd0;
               pos_d    = 8'd0;
               pidx_d   = 8'd0;
            end
         end
         default: cnt_d = '0;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         bitcnt_q <= 5'd0;
         sh_q     <= '0;
         pdata_q  <= '0;
         pidx_q   <= 8'd0;
         pos_q    <= 8'd0;
         valid_q  <= 1'b0;
         fd_q     <= 1'b0;
         err_q    <= 1'b0;
         ovr_q    <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         bitcnt_q <= bitcnt_d;
         sh_q     <= sh_d;
         pdata_q  <= pdata_d;
         pidx_q   <= pidx_d;
         pos_q    <= pos_d;
         valid_q  <= valid_d;
         fd_q     <= fd_d;
         err_q    <= err_d;
         ovr_q    <= ovr_d;
      end
   end

   assign pixel_data  = pdata_q;
   assign pixel_index = pidx_q;
   assign pixel_valid = valid_q;
   assign frame_done  = fd_q;
   assign err         = err_q;
   assign overrun     = ovr_q;

`ifdef WS2812_RX_PASSTHRU_EN
   // raw synchronized line, blanked while this node consumes pixel 0 of a frame
   logic dout_q;
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) dout_q <= 1'b0;
      else        dout_q <= (line ^ INVERT) & ~(pos_q == 8'd0 && state_q != SYNC);
   end
   assign dout = dout_q;
`else
   assign dout = 1'b0;
`endif
endmodule

// File: tb/tb_ws2812_rx.sv
// tb_ws2812_rx: directed bench for ws2812_rx (default 12 MHz timing, inverted line).
module tb_ws2812_rx;
   logic        clk_in = 1'b0, rst_n = 1'b0, rx_in = 1'b1, pixel_ready = 1'b0;
   logic [23:0] pixel_data;
   logic [7:0]  pixel_index;
   logic        pixel_valid, frame_done, err, overrun, dout;

   ws2812_rx dut (
      .clk_in(clk_in), .rst_n(rst_n), .rx_in(rx_in),
      .pixel_data(pixel_data), .pixel_index(pixel_index), .pixel_valid(pixel_valid),
      .pixel_ready(pixel_ready), .frame_done(frame_done), .err(err),
      .overrun(overrun), .dout(dout)
   );

   always #5 clk_in = ~clk_in;

   int errors = 0, checks = 0;
   int fd_n = 0, err_n = 0, efd_n = 0;
   logic [23:0] hs_data[$];
   logic [7:0]  hs_idx[$];
   int pt_mode = 0, pt_bad = 0;
   logic [2:0] h = 3'b111;

   always @(posedge clk_in) begin
      if (rst_n) begin
         if (pixel_valid && pixel_ready) begin
            hs_data.push_back(pixel_data);
            hs_idx.push_back(pixel_index);
         end
         if (frame_done) fd_n++;
         if (err) err_n++;
         if (err && frame_done) efd_n++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      h = {h[1:0], rx_in};
      @(negedge clk_in);
      if (pt_mode == 1 && dout !== 1'b0) pt_bad++;
      if (pt_mode == 2 && dout !== h[2]) pt_bad++;
   endtask

   task automatic lvl(input logic w, input int n);
      rx_in = ~w;
      repeat (n) tick();
   endtask

   task automatic send_bit(input logic b);
      lvl(1'b1, b ? 8 : 4);
      lvl(1'b0, b ? 8 : 12);
   endtask

   task automatic send_pix(input logic [23:0] p);
      for (int i = 23; i >= 0; i--) send_bit(p[i]);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      rx_in = 1'b1;
      pixel_ready = 1'b0;
      repeat (3) @(negedge clk_in);
      rst_n = 1'b1;
   endtask

   initial begin
      int b, e, f, ef, kv, kf;
      logic [23:0] d;
      logic [7:0] ix;
      logic e_at;
      logic [23:0] pat;
      rst_n = 1'b0;
      repeat (3) @(negedge clk_in);
      chk("rst_data", pixel_data, 0);
      chk("rst_index", pixel_index, 0);
      chk("rst_valid", pixel_valid, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_err", err, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_dout", dout, 0);

      // single pixel 0xFF0000 with latency measurement
      do_reset();
      pixel_ready = 1'b1;
      b = hs_data.size(); e = err_n; f = fd_n;
      lvl(1'b0, 610);
      pat = 24'hFF0000;
      pt_mode = 1; pt_bad = 0;
      for (int i = 23; i >= 1; i--) send_bit(pat[i]);
      lvl(1'b1, 4);
      pt_mode = 0;
      rx_in = 1'b1;
      kv = 0; kf = 0; d = '0; ix = '1; e_at = 1'b1;
      for (int k = 1; k <= 700; k++) begin
         tick();
         if (pixel_valid && kv == 0) begin kv = k; d = pixel_data; ix = pixel_index; end
         if (frame_done && kf == 0) begin kf = k; e_at = err; end
      end
      chk("s1_valid_latency", kv, 5);
      chk("s1_data", d, 24'hFF0000);
      chk("s1_index", ix, 0);
      chk("s1_frame_done_latency", kf, 604);
      chk("s1_err_at_frame_done", e_at, 0);
      chk("s1_handshakes", hs_data.size() - b, 1);
      chk("s1_err_count", err_n - e, 0);
      chk("s1_frames", fd_n - f, 1);
      chk("s1_dout_blank", pt_bad, 0);

      // three pixels in one frame
      do_reset();
      pixel_ready = 1'b1;
      b = hs_data.size(); e = err_n; f = fd_n;
      lvl(1'b0, 610);
      send_pix(24'h123456);
      send_pix(24'hABCDEF);
      send_pix(24'h000001);
      lvl(1'b0, 620);
      chk("s2_handshakes", hs_data.size() - b, 3);
      chk("s2_data0", hs_data[b], 24'h123456);
      chk("s2_idx0", hs_idx[b], 0);
      chk("s2_data1", hs_data[b+1], 24'hABCDEF);
      chk("s2_idx1", hs_idx[b+1], 1);
      chk("s2_data2", hs_data[b+2], 24'h000001);
      chk("s2_idx2", hs_idx[b+2], 2);
      chk("s2_frames", fd_n - f, 1);
      chk("s2_err_count", err_n - e, 0);

      // 1-clock glitch mid-pixel, then recovery
      do_reset();
      pixel_ready = 1'b1;
      b = hs_data.size(); e = err_n; f = fd_n;
      lvl(1'b0, 610);
      pat = 24'h000C3D;
      for (int i = 9; i >= 0; i--) send_bit(pat[i]);
      lvl(1'b1, 1);
      lvl(1'b0, 6);
      chk("s3_glitch_err", err_n - e, 1);
      chk("s3_no_pixel", hs_data.size() - b, 0);
      lvl(1'b0, 610);
      send_pix(24'hA5A5A5);
      lvl(1'b0, 620);
      chk("s3_handshakes", hs_data.size() - b, 1);
      chk("s3_data", hs_data[b], 24'hA5A5A5);
      chk("s3_index", hs_idx[b], 0);
      chk("s3_err_total", err_n - e, 1);
      chk("s3_frames", fd_n - f, 1);

      // 20 bits then latch gap
      do_reset();
      pixel_ready = 1'b1;
      b = hs_data.size(); e = err_n; f = fd_n; ef = efd_n;
      lvl(1'b0, 610);
      for (int i = 0; i < 20; i++) send_bit(i[0]);
      lvl(1'b0, 620);
      chk("s4_frames", fd_n - f, 1);
      chk("s4_err", err_n - e, 1);
      chk("s4_err_with_fd", efd_n - ef, 1);
      chk("s4_no_pixel", hs_data.size() - b, 0);

      // over-long high pulse
      e = err_n;
      lvl(1'b1, 14);
      lvl(1'b0, 6);
      chk("s5_long_high_err", err_n - e, 1);

      // overrun with consumer stalled
      do_reset();
      lvl(1'b0, 610);
      send_pix(24'h111111);
      chk("s6_valid1", pixel_valid, 1);
      chk("s6_data1", pixel_data, 24'h111111);
      chk("s6_idx1", pixel_index, 0);
      chk("s6_no_overrun", overrun, 0);
      send_pix(24'h222222);
      chk("s6_overrun", overrun, 1);
      chk("s6_valid2", pixel_valid, 1);
      chk("s6_data2", pixel_data, 24'h222222);
      chk("s6_idx2", pixel_index, 1);
      pixel_ready = 1'b1;
      tick();
      tick();
      chk("s6_valid_drop", pixel_valid, 0);
      chk("s6_overrun_sticky", overrun, 1);

`ifdef WS2812_RX_PASSTHRU_EN
      // pass-through: pixel 0 blanked, pixel 1 mirrored with 3-clock delay
      do_reset();
      pixel_ready = 1'b1;
      lvl(1'b0, 610);
      pat = 24'h5A5A5A;
      pt_mode = 1; pt_bad = 0;
      for (int i = 23; i >= 1; i--) send_bit(pat[i]);
      lvl(1'b1, 4);
      pt_mode = 0;
      lvl(1'b0, 12);
      chk("s7_pixel0_blank", pt_bad, 0);
      pt_mode = 2; pt_bad = 0;
      send_pix(24'h3C3C3C);
      pt_mode = 0;
      chk("s7_pixel1_mirror", pt_bad, 0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
